// File: rtl/pwm_frame_sequencer_if.sv
// Sample handshake between the network-fed sample buffer and the frame sequencer.
interface pwm_frame_sequencer_if;
    logic [23:0] sample_in;
    logic        sample_valid_in;
    logic        sample_ready_out;

    modport master (output sample_in, output sample_valid_in, input sample_ready_out);
    modport slave  (input sample_in, input sample_valid_in, output sample_ready_out);
endinterface

// File: rtl/pwm_frame_sequencer.sv
// Holds each RGB sample for a fixed dwell time and drives slew-limited duties into three pwm instances.
// state | meaning
// IDLE  | blanked, outputs forced to 0, waiting for a first sample while enabled
// RUN   | duties slew toward target; dwell counter paces target changes
// STOP  | controlled ramp-down to 0 after enable drops; returns to IDLE when dark
module pwm_frame_sequencer #(
    parameter int DWELL_CYCLES   = 1000,
    parameter int STEP_MAX       = 16,
    parameter int UNDERRUN_LIMIT = 2
) (
    input  logic                         clock_in,
    input  logic                         reset_n_in,
    input  logic                         enable_in,
    pwm_frame_sequencer_if.slave         sample_bus,
    output logic [7:0]                   red_out,
    output logic [7:0]                   green_out,
    output logic [7:0]                   blue_out,
    output logic                         blanked_out,
    output logic                         underrun_out
);

    localparam int CW = $clog2(DWELL_CYCLES);
    localparam int MW = $clog2(UNDERRUN_LIMIT + 1);
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [MW-1:0] MISS_LIMIT = MW'(UNDERRUN_LIMIT);
    localparam logic [MW-1:0] MISS_ONE   = MW'(1);
    localparam logic signed [8:0] STEP_S = 9'(STEP_MAX);

    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

    state_t               state_q, state_d;
    logic [2:0][7:0]      target_q, target_d;
    logic [2:0][7:0]      next_q, next_d;
    logic [2:0][7:0]      duty_q, duty_d;
    logic                 next_valid_q, next_valid_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [MW-1:0]        miss_q, miss_d;
    logic                 underrun_q, underrun_d;
    logic                 blanked_q;
    logic                 ready;
    logic                 xfer;

    // Clamped step keeps the sum inside 0..255, so truncating the 9-bit sum is exact.
    function automatic logic [7:0] slew(input logic [7:0] cur, input logic [7:0] tgt);
        logic signed [8:0] diff;
        logic signed [8:0] step;
        logic [8:0]        sum;
        diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
        if (diff > STEP_S)
            step = STEP_S;
        else if (diff < -STEP_S)
            step = -STEP_S;
        else
            step = diff;
        sum = {1'b0, cur} + $unsigned(step);
        return sum[7:0];
    endfunction

    always_comb begin
        ready = 1'b0;
        case (state_q)
            IDLE:    ready = enable_in;
            RUN:     ready = !next_valid_q || (cnt_q == '0);
            default: ready = 1'b0;
        endcase
    end

    assign sample_bus.sample_ready_out = ready && reset_n_in;
    assign xfer = sample_bus.sample_valid_in && ready;

    always_comb begin
        state_d      = state_q;
        target_d     = target_q;
        next_d       = next_q;
        next_valid_d = next_valid_q;
        cnt_d        = cnt_q;
        miss_d       = miss_q;
        underrun_d   = 1'b0;
        for (int i = 0; i < 3; i++)
            duty_d[i] = slew(duty_q[i], target_q[i]);

        case (state_q)
            IDLE: begin
                duty_d = '0;
                if (xfer) begin
                    target_d = sample_bus.sample_in;
                    cnt_d    = DWELL_LAST;
                    miss_d   = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (!enable_in) begin
                    state_d      = STOP;
                    target_d     = '0;
                    next_valid_d = 1'b0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (xfer) begin
                        next_d       = sample_bus.sample_in;
                        next_valid_d = 1'b1;
                    end
                end else begin
                    cnt_d = DWELL_LAST;
                    if (next_valid_q) begin
                        target_d     = next_q;
                        miss_d       = '0;
                        next_valid_d = xfer;
                        if (xfer)
                            next_d = sample_bus.sample_in;
                    end else if (xfer) begin
                        target_d = sample_bus.sample_in;
                        miss_d   = '0;
                    end else begin
                        underrun_d = 1'b1;
                        if (miss_q + MISS_ONE == MISS_LIMIT) begin
                            state_d      = IDLE;
                            next_valid_d = 1'b0;
                            miss_d       = '0;
                        end else begin
                            miss_d = miss_q + MISS_ONE;
                        end
                    end
                end
            end
            STOP: begin
                if (duty_q == '0)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q      <= IDLE;
            target_q     <= '0;
            next_q       <= '0;
            next_valid_q <= 1'b0;
            duty_q       <= '0;
            cnt_q        <= '0;
            miss_q       <= '0;
            underrun_q   <= 1'b0;
            blanked_q    <= 1'b1;
        end else begin
            state_q      <= state_d;
            target_q     <= target_d;
            next_q       <= next_d;
            next_valid_q <= next_valid_d;
            duty_q       <= duty_d;
            cnt_q        <= cnt_d;
            miss_q       <= miss_d;
            underrun_q   <= underrun_d;
            blanked_q    <= (state_q == IDLE);
        end
    end

    assign red_out      = duty_q[2];
    assign green_out    = duty_q[1];
    assign blue_out     = duty_q[0];
    assign blanked_out  = blanked_q;
    assign underrun_out = underrun_q;

endmodule

// File: doc/pwm_frame_sequencer.md
# pwm_frame_sequencer

Sequences laser intensity samples into the three per-colour `pwm` duty inputs (red, green, blue). It accepts 24-bit RGB samples over a valid/ready handshake and holds each one for a fixed dwell time. Duty changes are slew-limited so the diodes never see a step larger than `STEP_MAX`. If the sample stream starves, or the projector is disabled, the block forces the outputs to a blanked (zero) state. It sits between the network-fed sample buffer and the three `pwm` instances.

## Interface
- `DWELL_CYCLES`, 1000: clock cycles each sample is held (≥2).
- `STEP_MAX`, 16: max duty change per channel per cycle (1..255).
- `UNDERRUN_LIMIT`, 2: consecutive starved dwell ends before forced blanking (≥1).

- `clock_in`  in  1  system clock.
- `reset_n_in`  in  1  asynchronous, active-low reset.
- `enable_in`  in  1  run request; low requests a controlled ramp-down.
- `sample_in`  in  24  {red[23:16], green[15:8], blue[7:0]} target duties.
- `sample_valid_in`  in  1  sample_in valid.
- `sample_ready_out`  out  1  block accepts sample this cycle (combinational).
- `red_out`, `green_out`, `blue_out`  out  8 each  registered duty values to `pwm.value`.
- `blanked_out`  out  1  registered; 1 when in IDLE.
- `underrun_out`  out  1  registered one-cycle pulse per starved dwell end.

## Operation
- Transfer occurs when `sample_valid_in && sample_ready_out` at a rising edge.
- Internal state:
  - `target[3]`;
  - one-entry holding register `next` with flag `next_valid`;
  - dwell counter, width `$clog2(DWELL_CYCLES)`, counts down to 0;
  - miss counter, width `$clog2(UNDERRUN_LIMIT+1)`.
- FSM states: IDLE, RUN, STOP.
- IDLE:
  - outputs 0, `blanked_out`=1, `sample_ready_out`=`enable_in`;
  - on transfer: target←sample, counter←DWELL_CYCLES-1, miss←0, go RUN.
- RUN:
  - `sample_ready_out` = !`next_valid` || counter==0.
  - Transfer with counter≠0: sample written to `next`.
  - At counter==0, if `next_valid`: target←next, clear `next_valid` (or reload it if a transfer also occurs this cycle), reload counter, miss←0.
  - At counter==0, if !`next_valid` but a transfer occurs: bypass, target←sample directly, reload counter, miss←0.
  - At counter==0, if neither: pulse `underrun_out`, hold target, reload counter, miss+1. If miss+1==UNDERRUN_LIMIT: go IDLE, all outputs 0 on the next edge with no slew, `next` cleared.
  - `enable_in`=0 (checked before dwell logic): go STOP, target←0 on all channels, `next_valid` cleared.
- STOP:
  - `sample_ready_out`=0, counter frozen;
  - channels slew toward 0;
  - when all three outputs are 0, go IDLE.
  - `enable_in` re-asserted in STOP has no effect until IDLE is reached.
- Slew, each cycle in RUN/STOP, per channel:
  - diff = target − current, as 9-bit signed;
  - current += diff clamped to [−STEP_MAX, +STEP_MAX];
  - never overshoots target, never wraps outside 0..255.

## Timing
- Reset (async, immediate, no clock edge needed):
  - state IDLE;
  - all duty outputs 0;
  - `blanked_out`=1;
  - `underrun_out`=0;
  - `sample_ready_out`=0 while reset is low;
  - `next_valid`=0, counters 0.
- Accept in IDLE at edge N:
  - edge N+1: `blanked_out`=0;
  - each channel = min(target, STEP_MAX).
- Dwell period is exactly DWELL_CYCLES cycles from load to the next target change under continuous supply.
- `underrun_out` asserts for exactly the cycle after the starved dwell-end edge.
- Forced blank takes effect at the edge following the limiting dwell end.
- Enable deassertion: first ramp-down step is visible on the following edge.

## Test plan
- Params DWELL_CYCLES=8, STEP_MAX=16, UNDERRUN_LIMIT=2.
  - Stimulus: enable, push {0x80,0x10,0xFF}, then keep supplying samples.
  - Required: red 0x10,0x20..0x80 over 8 cycles; green 0x10 after 1 cycle; blue +16 per cycle, reaching 0x80 at the first dwell end.
- Back-to-back stream of 4 samples with valid held high:
  - `sample_ready_out` drops while `next` is full;
  - target changes every 8 cycles exactly;
  - `underrun_out` never asserts.
- One sample, then valid low:
  - `underrun_out` pulse after dwell 1;
  - after dwell 2, outputs 0 and `blanked_out`=1 on the next edge.
- Sample presented exactly at counter==0 with `next` empty: bypass taken, target updates the same edge, no underrun pulse.
- In RUN with outputs at 0x80, drop `enable_in`:
  - outputs 0x70,0x60..0x00 over 8 cycles;
  - ready held 0;
  - pending sample discarded;
  - then IDLE with `blanked_out`=1.
- Assert `reset_n_in` mid-RUN between clock edges: outputs 0 and `blanked_out`=1 immediately, before the next edge.
